// File: rtl/audio_path_ctrl.sv
// Per-channel audio sample sequencer: sample-rate strobe, filter start/done handshake,
// per-channel output mode with saturation and attenuation, and codec-paced output latch.
module audio_path_ctrl #(
   parameter int unsigned DATA_W = 24,
   parameter int unsigned CH     = 2,
   parameter int unsigned DIV    = 50000,
   parameter int unsigned TMO    = 4096
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [CH*DATA_W-1:0] src_data,
   output logic [CH*DATA_W-1:0] filt_data_in,
   output logic                 filt_start,
   input  logic                 filt_done,
   input  logic [CH*DATA_W-1:0] filt_data_out,
   input  logic [2*CH-1:0]      mode,
   input  logic [3:0]           atten,
   input  logic                 codec_ready,
   output logic [CH*DATA_W-1:0] dac_data,
   output logic                 dac_valid,
   output logic                 overrun,
   output logic                 timeout,
   input  logic                 clr_flags
);

   localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned TmoW = (TMO > 1) ? $clog2(TMO) : 1;

   typedef enum logic [1:0] {StIdle, StStart, StWait, StMix} state_e;

   state_e                state_q, state_d;
   logic [DivW-1:0]       div_cnt_q;
   logic [TmoW-1:0]       tmo_cnt_q, tmo_cnt_d;
   logic [CH*DATA_W-1:0]  src_q, src_d;
   logic [CH*DATA_W-1:0]  filt_q, filt_d;
   logic [CH*DATA_W-1:0]  res_q, res_d;
   logic [CH*DATA_W-1:0]  filt_in_q, filt_in_d;
   logic [CH*DATA_W-1:0]  dac_data_q, dac_data_d;
   logic [CH*DATA_W-1:0]  mix_res;
   logic [2*CH-1:0]       mode_q, mode_d;
   logic [3:0]            atten_q, atten_d;
   logic                  pending_q, pending_d;
   logic                  dac_valid_q, dac_valid_d;
   logic                  overrun_q, timeout_q;
   logic                  overrun_set, timeout_set;
   logic                  strobe;

   logic signed [DATA_W-1:0] ch_src, ch_filt, ch_sel;
   logic signed [DATA_W:0]   ch_diff;

   assign strobe       = (div_cnt_q == DivW'(DIV - 1));
   assign filt_start   = (state_q == StStart);
   assign filt_data_in = filt_in_q;
   assign dac_data     = dac_data_q;
   assign dac_valid    = dac_valid_q;
   assign overrun      = overrun_q;
   assign timeout      = timeout_q;

   // Per-channel mix from the shadowed mode; residual saturates before the shift.
   always_comb begin
      mix_res = '0;
      ch_src  = '0;
      ch_filt = '0;
      ch_sel  = '0;
      ch_diff = '0;
      for (int c = 0; c < int'(CH); c++) begin
         ch_src  = src_q[c*DATA_W +: DATA_W];
         ch_filt = filt_q[c*DATA_W +: DATA_W];
         ch_diff = {ch_src[DATA_W-1], ch_src} - {ch_filt[DATA_W-1], ch_filt};
         unique case (mode_q[2*c +: 2])
            2'b00: ch_sel = ch_src;
            2'b01: ch_sel = ch_filt;
            2'b10: ch_sel = '0;
            2'b11: begin
               if (ch_diff[DATA_W] != ch_diff[DATA_W-1]) begin
                  ch_sel = ch_diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                           : {1'b0, {(DATA_W-1){1'b1}}};
               end else begin
                  ch_sel = ch_diff[DATA_W-1:0];
               end
            end
         endcase
         mix_res[c*DATA_W +: DATA_W] = ch_sel >>> atten_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      tmo_cnt_d   = tmo_cnt_q;
      src_d       = src_q;
      filt_d      = filt_q;
      res_d       = res_q;
      filt_in_d   = filt_in_q;
      mode_d      = mode_q;
      atten_d     = atten_q;
      pending_d   = pending_q;
      dac_data_d  = dac_data_q;
      dac_valid_d = 1'b0;
      timeout_set = 1'b0;
      overrun_set = strobe && (state_q != StIdle);

      unique case (state_q)
         StIdle: begin
            if (strobe) begin
               src_d     = src_data;
               filt_in_d = src_data;
               mode_d    = mode;
               atten_d   = atten;
               state_d   = StStart;
            end
         end
         StStart: begin
            tmo_cnt_d = '0;
            state_d   = StWait;
         end
         StWait: begin
            if (filt_done) begin
               filt_d  = filt_data_out;
               state_d = StMix;
            end else if (tmo_cnt_q == TmoW'(TMO - 1)) begin
               // Filter gave no answer: fall back to the source so mode 01 acts as bypass.
               timeout_set = 1'b1;
               filt_d      = src_q;
               state_d     = StMix;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TmoW'(1);
            end
         end
         StMix: begin
            res_d     = mix_res;
            pending_d = 1'b1;
            state_d   = StIdle;
         end
      endcase

      // A MIX in the same cycle re-arms pending for the newer result.
      if (codec_ready && pending_q) begin
         dac_data_d  = res_q;
         dac_valid_d = 1'b1;
         pending_d   = (state_q == StMix);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         div_cnt_q   <= '0;
         tmo_cnt_q   <= '0;
         src_q       <= '0;
         filt_q      <= '0;
         res_q       <= '0;
         filt_in_q   <= '0;
         mode_q      <= '0;
         atten_q     <= '0;
         pending_q   <= 1'b0;
         dac_data_q  <= '0;
         dac_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_cnt_q   <= strobe ? '0 : div_cnt_q + DivW'(1);
         tmo_cnt_q   <= tmo_cnt_d;
         src_q       <= src_d;
         filt_q      <= filt_d;
         res_q       <= res_d;
         filt_in_q   <= filt_in_d;
         mode_q      <= mode_d;
         atten_q     <= atten_d;
         pending_q   <= pending_d;
         dac_data_q  <= dac_data_d;
         dac_valid_q <= dac_valid_d;
         overrun_q   <= overrun_set | (overrun_q & ~clr_flags);
         timeout_q   <= timeout_set | (timeout_q & ~clr_flags);
      end
   end

endmodule

// File: tb/tb_audio_path_ctrl.sv
// Self-checking bench for audio_path_ctrl: scenario tasks with randomized frames
// checked against an arithmetic reference of the per-channel mix.
module tb_audio_path_ctrl;

   localparam int DW   = 24;
   localparam int NCH  = 2;
   localparam int W    = DW * NCH;
   localparam int DIVP = 12;
   localparam int TMOP = 16;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic [W-1:0]   src_data = '0;
   logic [W-1:0]   filt_data_in;
   logic           filt_start;
   logic           filt_done = 1'b0;
   logic [W-1:0]   filt_data_out = '0;
   logic [2*NCH-1:0] mode = '0;
   logic [3:0]     atten = '0;
   logic           codec_ready;
   logic [W-1:0]   dac_data;
   logic           dac_valid;
   logic           overrun;
   logic           timeout;
   logic           clr_flags = 1'b0;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int last_start = 0;
   int prev_start = 0;
   bit ready_en = 1'b0;

   audio_path_ctrl #(
      .DATA_W(DW),
      .CH    (NCH),
      .DIV   (DIVP),
      .TMO   (TMOP)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .src_data     (src_data),
      .filt_data_in (filt_data_in),
      .filt_start   (filt_start),
      .filt_done    (filt_done),
      .filt_data_out(filt_data_out),
      .mode         (mode),
      .atten        (atten),
      .codec_ready  (codec_ready),
      .dac_data     (dac_data),
      .dac_valid    (dac_valid),
      .overrun      (overrun),
      .timeout      (timeout),
      .clr_flags    (clr_flags)
   );

   always #5 clk = ~clk;

   // Codec requests a frame every 4 cycles while enabled.
   initial begin
      int rph;
      rph = 0;
      codec_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         rph++;
         codec_ready = ready_en && (rph % 4 == 0);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [W-1:0] rnd_w();
      return W'({$urandom(), $urandom()});
   endfunction

   // Reference: each channel from the mode rules using plain signed integer arithmetic.
   function automatic logic [W-1:0] ref_frame(input logic [W-1:0] s, input logic [W-1:0] f,
                                               input logic [2*NCH-1:0] m, input logic [3:0] a);
      logic [W-1:0] r;
      longint sv, fv, v, hi, lo;
      hi = (longint'(1) << (DW - 1)) - 1;
      lo = -hi - 1;
      r = '0;
      for (int c = 0; c < NCH; c++) begin
         sv = longint'($signed(s[c*DW +: DW]));
         fv = longint'($signed(f[c*DW +: DW]));
         case (m[2*c +: 2])
            2'b00:   v = sv;
            2'b01:   v = fv;
            2'b10:   v = 0;
            default: begin
               v = sv - fv;
               if (v > hi) v = hi;
               else if (v < lo) v = lo;
            end
         endcase
         v = v >>> a;
         r[c*DW +: DW] = v[DW-1:0];
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_start(input string name, input int gap);
      int n;
      n = 0;
      while (filt_start !== 1'b1 && n < 3 * DIVP) begin
         tick();
         n++;
      end
      prev_start = last_start;
      last_start = cyc;
      total++;
      if (filt_start !== 1'b1) begin
         bad++;
         $display("FAIL %s start: filt_start=%b after %0d cycles, want 1", name, filt_start, n);
      end else begin
         total++;
         if (cyc % DIVP != 0) begin
            bad++;
            $display("FAIL %s start_phase: filt_start at cycle %0d, want multiple of %0d",
                     name, cyc, DIVP);
         end
         total++;
         if (filt_data_in !== src_data) begin
            bad++;
            $display("FAIL %s filt_data_in: got %h want %h", name, filt_data_in, src_data);
         end
         if (gap != 0) begin
            total++;
            if (last_start - prev_start != gap) begin
               bad++;
               $display("FAIL %s start_gap: got %0d want %0d", name, last_start - prev_start,
                        gap);
            end
         end
      end
   endtask

   // Waits for the frame's dac_valid, then idles to the cycle before the next strobe.
   task automatic wait_dac(input string name, input logic [W-1:0] exp);
      int n, extra;
      n = 0;
      while (dac_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      total++;
      if (dac_valid !== 1'b1) begin
         bad++;
         $display("FAIL %s dac_valid: got %b want 1 within 40 cycles", name, dac_valid);
      end else begin
         total++;
         if (dac_data !== exp) begin
            bad++;
            $display("FAIL %s dac_data: got %h want %h", name, dac_data, exp);
         end
      end
      extra = 0;
      n = 0;
      while (cyc % DIVP != DIVP - 1 && n < 2 * DIVP) begin
         tick();
         if (dac_valid === 1'b1) extra++;
         n++;
      end
      total++;
      if (extra != 0) begin
         bad++;
         $display("FAIL %s extra_valid: got %0d extra pulses want 0", name, extra);
      end
   endtask

   // One frame: lat = cycles from filt_start to filt_done (0 = filter never answers).
   task automatic run_frame(input string name, input logic [W-1:0] s, input logic [2*NCH-1:0] m,
                            input logic [3:0] a, input logic [W-1:0] f, input int lat,
                            input int gap, input logic [W-1:0] exp);
      src_data = s;
      mode = m;
      atten = a;
      wait_start(name, gap);
      // Done during START must be ignored; input changes must not reach this frame.
      filt_done = 1'b1;
      filt_data_out = rnd_w();
      mode = 4'($urandom());
      atten = 4'($urandom());
      src_data = rnd_w();
      tick();
      filt_done = 1'b0;
      if (lat > 0) begin
         repeat (lat - 1) tick();
         filt_done = 1'b1;
         filt_data_out = f;
         tick();
         filt_done = 1'b0;
         filt_data_out = rnd_w();
      end
      wait_dac(name, exp);
   endtask

   task automatic check_zero_outputs(input string name);
      total += 6;
      if (dac_data !== '0) begin
         bad++; $display("FAIL %s dac_data: got %h want 0", name, dac_data);
      end
      if (dac_valid !== 1'b0) begin
         bad++; $display("FAIL %s dac_valid: got %b want 0", name, dac_valid);
      end
      if (filt_start !== 1'b0) begin
         bad++; $display("FAIL %s filt_start: got %b want 0", name, filt_start);
      end
      if (filt_data_in !== '0) begin
         bad++; $display("FAIL %s filt_data_in: got %h want 0", name, filt_data_in);
      end
      if (overrun !== 1'b0) begin
         bad++; $display("FAIL %s overrun: got %b want 0", name, overrun);
      end
      if (timeout !== 1'b0) begin
         bad++; $display("FAIL %s timeout: got %b want 0", name, timeout);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) tick();
      check_zero_outputs("reset");
      reset_n = 1'b1;
      cyc = 0;
   endtask

   task automatic test_bypass();
      ready_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         run_frame("bypass", {24'hF00000, 24'h100000}, 4'b0000, 4'd0,
                   {24'h000001, 24'h000001}, 5, 0, {24'hF00000, 24'h100000});
      end
   endtask

   task automatic test_filtered();
      run_frame("filt_resid_a", {24'h7FFFFF, 24'h7FFFFF}, 4'b1101, 4'd0,
                {24'h800000, 24'h800000}, 3, 0, {24'h7FFFFF, 24'h800000});
      run_frame("filt_resid_b", {24'h800000, 24'h800000}, 4'b1101, 4'd0,
                {24'h7FFFFF, 24'h7FFFFF}, 4, 0, {24'h800000, 24'h7FFFFF});
   endtask

   task automatic test_mute_atten();
      run_frame("mute_atten", {24'hF00000, 24'h3ABCDE}, 4'b0010, 4'd4,
                {24'h000001, 24'h000001}, 2, 0, {24'hFF0000, 24'h000000});
   endtask

   task automatic test_random();
      logic [W-1:0] s, f;
      logic [2*NCH-1:0] m;
      logic [3:0] a;
      for (int i = 0; i < 12; i++) begin
         s = rnd_w();
         f = rnd_w();
         m = 4'($urandom());
         a = (i % 2 == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
         run_frame("random", s, m, a, f, int'($urandom_range(1, 5)), 0, ref_frame(s, f, m, a));
      end
   endtask

   task automatic test_overrun();
      logic [W-1:0] s, f;
      total++;
      if (overrun !== 1'b0) begin
         bad++; $display("FAIL overrun_pre: got %b want 0", overrun);
      end
      s = rnd_w();
      f = rnd_w();
      run_frame("overrun_slow", s, 4'b0111, 4'd1, f, 14, 0, ref_frame(s, f, 4'b0111, 4'd1));
      total += 2;
      if (overrun !== 1'b1) begin
         bad++; $display("FAIL overrun_set: got %b want 1", overrun);
      end
      if (timeout !== 1'b0) begin
         bad++; $display("FAIL overrun_no_timeout: got %b want 0", timeout);
      end
      s = rnd_w();
      f = rnd_w();
      run_frame("overrun_next", s, 4'b1001, 4'd0, f, 3, 2 * DIVP, ref_frame(s, f, 4'b1001, 4'd0));
   endtask

   task automatic test_timeout();
      logic [W-1:0] s;
      int t0;
      s = {24'h654321, 24'h123456};
      src_data = s;
      mode = 4'b0101;
      atten = 4'd0;
      wait_start("timeout_a", 0);
      t0 = cyc;
      while (cyc < t0 + TMOP) tick();
      total++;
      if (timeout !== 1'b0) begin
         bad++; $display("FAIL timeout_early: got %b want 0", timeout);
      end
      tick();
      total++;
      if (timeout !== 1'b1) begin
         bad++; $display("FAIL timeout_set: got %b want 1", timeout);
      end
      wait_dac("timeout_a", s);

      s = rnd_w();
      src_data = s;
      mode = 4'b0101;
      wait_start("timeout_b", 0);
      t0 = cyc;
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      total += 2;
      if (timeout !== 1'b0) begin
         bad++; $display("FAIL clr_timeout: got %b want 0", timeout);
      end
      if (overrun !== 1'b0) begin
         bad++; $display("FAIL clr_overrun: got %b want 0", overrun);
      end
      while (cyc < t0 + TMOP) tick();
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      total++;
      if (timeout !== 1'b1) begin
         bad++; $display("FAIL timeout_set_wins: got %b want 1", timeout);
      end
      wait_dac("timeout_b", s);
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] s, f;
      int seen;
      ready_en = 1'b0;
      src_data = rnd_w();
      mode = 4'b0000;
      atten = 4'd0;
      wait_start("rst_mid_a", 0);
      src_data = rnd_w();
      repeat (2) tick();
      filt_done = 1'b1;
      filt_data_out = rnd_w();
      tick();
      filt_done = 1'b0;
      wait_start("rst_mid_b", 0);
      repeat (2) tick();
      reset_n = 1'b0;
      tick();
      check_zero_outputs("rst_mid");
      reset_n = 1'b1;
      cyc = 0;
      ready_en = 1'b1;
      seen = 0;
      while (cyc < DIVP - 1) begin
         tick();
         if (dac_valid === 1'b1) seen++;
      end
      total++;
      if (seen != 0) begin
         bad++; $display("FAIL rst_mid_stale_valid: got %0d pulses want 0", seen);
      end
      s = rnd_w();
      f = rnd_w();
      run_frame("post_reset", s, 4'b1110, 4'd2, f, 4, 0, ref_frame(s, f, 4'b1110, 4'd2));
      total++;
      if (last_start != DIVP) begin
         bad++; $display("FAIL post_reset_first_start: got cycle %0d want %0d", last_start, DIVP);
      end
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_filtered();
      test_mute_atten();
      test_random();
      test_overrun();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
